// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcode, state and width definitions shared with the flash controller
package spi_flash_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WAKE  = 8'hAB;
    localparam logic [7:0] OP_SLEEP = 8'hB9;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } flash_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-flop pin synchronizer with rise/fall detection
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer and keep one extra sample for edge detection.
    // Reset value is 0 so that a chip select held low across reset never looks like a new falling edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 serial flash read responder
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic START_AWAKE = 1'b0,
    parameter int   SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              SPI_CS,
    input  logic              SPI_SCK,
    input  logic              SPI_SI,
    output logic              SPI_SO,
    output logic              SPI_SO_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              awake,
    output logic              bad_opcode
);

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic si_level, si_rise, si_fall;
    logic sync_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .CLK   (CLK),
        .reset (reset),
        .pin   (SPI_CS),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .CLK   (CLK),
        .reset (reset),
        .pin   (SPI_SCK),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_si (
        .CLK   (CLK),
        .reset (reset),
        .pin   (SPI_SI),
        .level (si_level),
        .rise  (si_rise),
        .fall  (si_fall)
    );

    assign sync_unused = sck_level ^ si_rise ^ si_fall;

    flash_state_t      state;
    logic [4:0]        bit_cnt;
    logic [6:0]        cmd_sh;
    logic [ADDR_W-2:0] addr_sh;
    logic [7:0]        out_sh;
    logic [7:0]        next_byte;
    logic [3:0]        fall_cnt;
    logic              rd_wait;
    logic              first_fetch;
    logic              prefetch_req;
    logic              sleep_pending;
    logic [7:0]        opcode;

    // The opcode is complete on the cycle its eighth bit is sampled.
    assign opcode = {cmd_sh, si_level};

    // Transaction FSM: command/address decode, fetch/prefetch sequencing and SO shifting.
    // A new transaction only starts on a synchronized CS falling edge, so after a reset
    // that lands mid-transaction the device sits in IDLE until CS has been high again.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            cmd_sh        <= '0;
            addr_sh       <= '0;
            out_sh        <= '0;
            next_byte     <= '0;
            fall_cnt      <= '0;
            rd_wait       <= 1'b0;
            first_fetch   <= 1'b0;
            prefetch_req  <= 1'b0;
            sleep_pending <= 1'b0;
            SPI_SO        <= 1'b0;
            SPI_SO_oe     <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
            awake         <= START_AWAKE;
            bad_opcode    <= 1'b0;
        end else begin
            mem_rd_en    <= 1'b0;
            bad_opcode   <= 1'b0;
            prefetch_req <= 1'b0;
            rd_wait      <= mem_rd_en;

            if (cs_level) begin
                // CS high overrides any SCK edge seen this cycle and drops any in-flight fetch.
                state         <= IDLE;
                SPI_SO        <= 1'b0;
                SPI_SO_oe     <= 1'b0;
                rd_wait       <= 1'b0;
                sleep_pending <= 1'b0;
                if (cs_rise && sleep_pending) begin
                    awake <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (sck_rise) begin
                            cmd_sh  <= opcode[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                if (opcode == OP_READ && awake) begin
                                    state <= ADDR;
                                end else begin
                                    state <= IGNORE;
                                    if (opcode == OP_WAKE) begin
                                        awake <= 1'b1;
                                    end else if (opcode == OP_SLEEP) begin
                                        sleep_pending <= 1'b1;
                                    end else if (opcode != OP_READ) begin
                                        bad_opcode <= 1'b1;
                                    end
                                end
                            end
                        end
                    end

                    ADDR: begin
                        if (sck_rise) begin
                            addr_sh <= {addr_sh[ADDR_W-3:0], si_level};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'(ADDR_W - 1)) begin
                                mem_rd_en   <= 1'b1;
                                mem_addr    <= {addr_sh, si_level};
                                state       <= DATA;
                                SPI_SO_oe   <= 1'b1;
                                SPI_SO      <= 1'b0;
                                first_fetch <= 1'b1;
                                fall_cnt    <= '0;
                            end
                        end
                    end

                    DATA: begin
                        // First fetch goes straight to the shifter; later ones refill the buffer.
                        if (rd_wait) begin
                            if (first_fetch) begin
                                out_sh       <= mem_rdata;
                                first_fetch  <= 1'b0;
                                prefetch_req <= 1'b1;
                            end else begin
                                next_byte <= mem_rdata;
                            end
                        end
                        if (prefetch_req) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= mem_addr + 24'd1;
                        end
                        if (sck_fall) begin
                            if (fall_cnt == 4'd8) begin
                                SPI_SO       <= next_byte[7];
                                out_sh       <= {next_byte[6:0], 1'b0};
                                fall_cnt     <= 4'd1;
                                prefetch_req <= 1'b1;
                            end else begin
                                SPI_SO   <= out_sh[7];
                                out_sh   <= {out_sh[6:0], 1'b0};
                                fall_cnt <= fall_cnt + 4'd1;
                            end
                        end
                    end

                    IGNORE: begin
                        // Any rise past the eighth disqualifies a pending power-down.
                        if (sck_rise) begin
                            sleep_pending <= 1'b0;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - scoreboard bench for spi_flash_responder
module tb_spi_flash_responder;

    localparam int H = 6;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        SPI_CS = 1'b1;
    logic        SPI_SCK = 1'b0;
    logic        SPI_SI = 1'b0;
    logic        SPI_SO;
    logic        SPI_SO_oe;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        awake;
    logic        bad_opcode;

    int n_cmp = 0;
    int n_bad = 0;
    int oe_cyc = 0;
    int rd_cyc = 0;
    int bad_cyc = 0;
    bit model_awake = 1'b0;

    logic [23:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];

    logic [7:0] rx = 8'h00;
    int         rx_n = 0;

    always #5 CLK = ~CLK;

    spi_flash_responder #(.START_AWAKE(1'b0), .SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .SPI_CS     (SPI_CS),
        .SPI_SCK    (SPI_SCK),
        .SPI_SI     (SPI_SI),
        .SPI_SO     (SPI_SO),
        .SPI_SO_oe  (SPI_SO_oe),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .awake      (awake),
        .bad_opcode (bad_opcode)
    );

    function automatic logic [7:0] mem_f(input logic [7:0] a_lo);
        return a_lo ^ 8'hA5;
    endfunction

    always @(posedge CLK) begin
        if (mem_rd_en) mem_rdata <= mem_f(mem_addr[7:0]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: memory strobes against the address scoreboard, plus per-transaction activity counts.
    always @(negedge CLK) begin
        if (!reset) begin
            if (SPI_SO_oe) oe_cyc++;
            if (bad_opcode) bad_cyc++;
            if (!SPI_SO_oe && SPI_SO) begin
                n_cmp++;
                n_bad++;
                $display("FAIL so_when_off: got SO=1 with oe=0, required 0");
            end
            if (mem_rd_en) begin
                rd_cyc++;
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got strobe at 0x%0h, required none", mem_addr);
                end else begin
                    check("rd_addr", {8'h00, mem_addr}, {8'h00, exp_addr_q.pop_front()});
                end
            end
        end
    end

    // SO monitor: assembles bytes the way the master samples them, on SCK rise.
    always @(posedge SPI_SCK or posedge SPI_CS) begin
        if (SPI_CS) begin
            rx_n = 0;
        end else if (SPI_SO_oe) begin
            rx = {rx[6:0], SPI_SO};
            rx_n++;
            if (rx_n == 8) begin
                rx_n = 0;
                if (exp_byte_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL so_unexpected: got byte 0x%0h, required none", rx);
                end else begin
                    check("so_byte", {24'h0, rx}, {24'h0, exp_byte_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clock_bits(input logic [127:0] bits, input int n, input bit end_cs);
        for (int i = 0; i < n; i++) begin
            SPI_SI = bits[n-1-i];
            tick(H);
            SPI_SCK = 1'b1;
            tick(H);
            SPI_SCK = 1'b0;
            if (i == n - 1 && end_cs) SPI_CS = 1'b1;
        end
        SPI_SI = 1'b0;
    endtask

    task automatic begin_txn();
        oe_cyc  = 0;
        rd_cyc  = 0;
        bad_cyc = 0;
        SPI_CS  = 1'b0;
        tick(8);
    endtask

    task automatic end_txn(input string tag, input bit exp_oe, input int exp_rd, input int exp_bad);
        tick(16);
        check({tag, "_rd_count"}, rd_cyc, exp_rd);
        check({tag, "_bad_pulse"}, bad_cyc, exp_bad);
        check({tag, "_oe_seen"}, {31'h0, oe_cyc != 0}, {31'h0, exp_oe});
        check({tag, "_awake"}, {31'h0, awake}, {31'h0, model_awake});
        check({tag, "_addr_q"}, exp_addr_q.size(), 0);
        check({tag, "_byte_q"}, exp_byte_q.size(), 0);
    endtask

    task automatic do_read(input logic [23:0] addr, input int nbytes, input string tag);
        logic [127:0] b;
        logic [23:0]  a;
        bit           ok;
        ok = model_awake;
        if (ok) begin
            for (int i = 0; i <= nbytes; i++) exp_addr_q.push_back(addr + 24'(i));
            for (int i = 0; i < nbytes; i++) begin
                a = addr + 24'(i);
                exp_byte_q.push_back(mem_f(a[7:0]));
            end
        end
        b = {96'h0, 8'h03, addr};
        for (int i = 0; i < nbytes; i++) b = {b[119:0], 8'($urandom)};
        begin_txn();
        clock_bits(b, 32 + 8 * nbytes, 1'b1);
        end_txn(tag, ok, ok ? nbytes + 1 : 0, 0);
    endtask

    task automatic do_cmd(input logic [7:0] op, input int rises, input string tag);
        logic [127:0] b;
        int           exp_bad;
        b = {120'h0, op};
        for (int i = 8; i < rises; i++) b = {b[126:0], 1'($urandom)};
        exp_bad = (op != 8'h03 && op != 8'hAB && op != 8'hB9) ? 1 : 0;
        begin_txn();
        clock_bits(b, rises, 1'b1);
        if (op == 8'hAB) model_awake = 1'b1;
        if (op == 8'hB9 && rises == 8) model_awake = 1'b0;
        end_txn(tag, 1'b0, 0, exp_bad);
    endtask

    initial begin
        int          kind;
        logic [23:0] raddr;
        logic [7:0]  rop;

        tick(5);
        check("rst_so", {31'h0, SPI_SO}, 0);
        check("rst_oe", {31'h0, SPI_SO_oe}, 0);
        check("rst_rd_en", {31'h0, mem_rd_en}, 0);
        check("rst_mem_addr", {8'h0, mem_addr}, 0);
        check("rst_awake", {31'h0, awake}, 0);
        check("rst_bad", {31'h0, bad_opcode}, 0);
        reset = 1'b0;
        tick(10);

        do_read(24'h000010, 4, "asleep_read");
        do_cmd(8'hAB, 8, "wake");
        do_read(24'h051000, 4, "read4");
        do_read(24'hFFFFFE, 3, "wrap");

        begin_txn();
        clock_bits({108'h0, 8'h03, 12'h000}, 20, 1'b1);
        end_txn("abort", 1'b0, 0, 0);
        do_read(24'h000100, 2, "after_abort");

        do_cmd(8'h9F, 8, "bad_op");
        do_cmd(8'hB9, 8, "sleep8");
        do_cmd(8'hAB, 8, "wake2");
        do_cmd(8'hB9, 9, "sleep9");

        for (int k = 0; k < 12; k++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin
                    raddr = 24'($urandom);
                    do_read(raddr, $urandom_range(1, 4), "rnd_read");
                end
                2: begin
                    raddr = 24'hFFFFFF - 24'($urandom_range(0, 3));
                    do_read(raddr, $urandom_range(1, 4), "rnd_wrap");
                end
                3: do_cmd(8'hAB, 8, "rnd_wake");
                4: do_cmd(8'hB9, 8 + $urandom_range(0, 1), "rnd_sleep");
                default: begin
                    rop = 8'($urandom);
                    while (rop == 8'h03 || rop == 8'hAB || rop == 8'hB9) rop = 8'($urandom);
                    do_cmd(rop, 8, "rnd_bad");
                end
            endcase
        end

        // Reset in the middle of a transaction: commands are ignored until CS has been high.
        begin_txn();
        clock_bits({108'h0, 8'h03, 12'h000}, 20, 1'b0);
        reset = 1'b1;
        tick(2);
        model_awake = 1'b0;
        check("midrst_oe", {31'h0, SPI_SO_oe}, 0);
        check("midrst_awake", {31'h0, awake}, 0);
        reset = 1'b0;
        tick(4);
        oe_cyc  = 0;
        rd_cyc  = 0;
        bad_cyc = 0;
        clock_bits({120'h0, 8'hAB}, 8, 1'b1);
        end_txn("midrst_ignored", 1'b0, 0, 0);
        do_cmd(8'hAB, 8, "midrst_wake");
        do_read(24'h0A0B0C, 2, "midrst_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
